// File: rtl/sample_buffer.sv
// sample_buffer: elastic PCM sample FIFO between the sample generator and
// the AC97 codec interface. The generator pushes with valid/ready; each codec
// frame-accept pulse pops one sample onto the registered sample_out. The
// buffer primes to half-full (FILL) before playback starts (RUN), and counts
// underruns with a saturating 16-bit counter.
//
// Optional feature macro: SAMPLE_BUFFER_HOLD_EN
//   defined   - during FILL and on underrun the last sample_out is repeated
//               (avoids clicks)
//   undefined - during FILL and on underrun the codec gets silence (0)
module sample_buffer #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_sample,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             accept,
  output logic [WIDTH-1:0] sample_out,
  output logic [AW:0]      level,
  output logic             primed,
  output logic [15:0]      underrun_count,
  input  logic             clear_stats
);

  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);
  localparam logic [AW:0] HALF_LEVEL = (AW+1)'(DEPTH / 2);

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic [AW:0]      level_w;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             underrun;
  logic [WIDTH-1:0] fill_value;
  logic [WIDTH-1:0] sample_out_reg;
  logic [15:0]      underrun_count_reg;
  logic [15:0]      underrun_count_next;

  // Pointers carry one extra MSB so that full and empty are distinguishable;
  // the subtraction wraps naturally modulo 2^(AW+1).
  assign level_w = wr_ptr_reg - rd_ptr_reg;
  assign full    = (level_w == FULL_LEVEL);
  assign empty   = (level_w == '0);

  // A full buffer refuses the push even if the codec pops in the same cycle,
  // which keeps in_ready purely register-derived.
  assign push     = in_valid & ~full;
  assign pop      = accept & (state_reg == RUN) & ~empty;
  assign underrun = accept & (state_reg == RUN) & empty;

`ifdef SAMPLE_BUFFER_HOLD_EN
  assign fill_value = sample_out_reg;
`else
  assign fill_value = '0;
`endif

  // Sample storage: plain write port, no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg[AW-1:0]] <= in_sample;
    end
  end

  // Read/write pointer advance on accepted push and successful pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
    end
  end

  // FILL/RUN control with the registered codec sample: FILL waits for
  // half-full, RUN pops per accept and falls back to FILL on an empty accept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= FILL;
      sample_out_reg <= '0;
    end else begin
      case (state_reg)
        FILL: begin
          if (accept) begin
            sample_out_reg <= fill_value;
          end
          if (level_w >= HALF_LEVEL) begin
            state_reg <= RUN;
          end
        end
        RUN: begin
          if (accept) begin
            if (!empty) begin
              sample_out_reg <= mem[rd_ptr_reg[AW-1:0]];
            end else begin
              sample_out_reg <= fill_value;
              state_reg      <= FILL;
            end
          end
        end
        default: state_reg <= FILL;
      endcase
    end
  end

  // Saturating underrun count; a clear in the same cycle as an underrun wins.
  always_comb begin
    underrun_count_next = underrun_count_reg;
    if (clear_stats) begin
      underrun_count_next = '0;
    end else if (underrun && (underrun_count_reg != 16'hFFFF)) begin
      underrun_count_next = underrun_count_reg + 16'd1;
    end
  end

  // Underrun counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      underrun_count_reg <= '0;
    end else begin
      underrun_count_reg <= underrun_count_next;
    end
  end

  assign in_ready       = ~full;
  assign level          = level_w;
  assign primed         = (state_reg == RUN);
  assign sample_out     = sample_out_reg;
  assign underrun_count = underrun_count_reg;

endmodule

// File: tb/tb_sample_buffer.sv
// tb_sample_buffer: directed stimulus for sample_buffer (DEPTH=8, WIDTH=16)
// with a queue-based reference model compared every cycle, plus literal
// expectations at the key points of each scenario.
module tb_sample_buffer;

  localparam int WIDTH = 16;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

`ifdef SAMPLE_BUFFER_HOLD_EN
  localparam logic [15:0] UNDERRUN_FILL = 16'h0004;
`else
  localparam logic [15:0] UNDERRUN_FILL = 16'h0000;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [WIDTH-1:0] in_sample = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             accept = 1'b0;
  logic [WIDTH-1:0] sample_out;
  logic [AW:0]      level;
  logic             primed;
  logic [15:0]      underrun_count;
  logic             clear_stats = 1'b0;

  always #5 clk = ~clk;

  sample_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_sample     (in_sample),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .accept        (accept),
    .sample_out    (sample_out),
    .level         (level),
    .primed        (primed),
    .underrun_count(underrun_count),
    .clear_stats   (clear_stats)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO contents as a queue, playback flag, output, count.
  logic [15:0] m_q[$];
  bit          m_run = 1'b0;
  logic [15:0] m_out = 16'h0;
  logic [15:0] m_cnt = 16'h0;

  initial begin : model_and_compare
    int          lvl;
    bit          was_run;
    bit          do_push;
    logic [15:0] fill;
    forever begin
      @(posedge clk);
      lvl = m_q.size();
      if (!reset) begin
        m_q.delete();
        m_run = 1'b0;
        m_out = 16'h0;
        m_cnt = 16'h0;
      end else begin
`ifdef SAMPLE_BUFFER_HOLD_EN
        fill = m_out;
`else
        fill = 16'h0;
`endif
        was_run = m_run;
        do_push = in_valid && (lvl < DEPTH);
        if (accept) begin
          if (was_run && lvl > 0) begin
            m_out = m_q.pop_front();
          end else begin
            m_out = fill;
            if (was_run) begin
              m_run = 1'b0;
              if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            end
          end
        end
        if (!was_run && lvl >= DEPTH / 2) m_run = 1'b1;
        if (clear_stats) m_cnt = 16'h0;
        if (do_push) m_q.push_back(in_sample);
      end
      #1;
      check("cyc_level", 32'(level), 32'(m_q.size()));
      check("cyc_in_ready", 32'(in_ready), 32'(m_q.size() < DEPTH));
      check("cyc_primed", 32'(primed), 32'(m_run));
      check("cyc_sample_out", 32'(sample_out), 32'(m_out));
      check("cyc_underrun_count", 32'(underrun_count), 32'(m_cnt));
      if (reset && accept)
        $display("accept: sample_out=%h level=%0d primed=%0d underruns=%0d",
                 sample_out, level, primed, underrun_count);
    end
  end

  // One cycle of stimulus, driven from the falling edge.
  task automatic step(input logic v, input logic [15:0] d, input logic a, input logic c);
    in_valid    = v;
    in_sample   = d;
    accept      = a;
    clear_stats = c;
    @(negedge clk);
    in_valid    = 1'b0;
    accept      = 1'b0;
    clear_stats = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Prime with 4 pushes, drain everything, then accept on empty.
  task automatic run_underrun(input logic push_at_end, input logic clr);
    int n;
    for (int i = 0; i < 4; i++) step(1'b1, 16'h4000 + 16'(i), 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b0, 1'b0);
    n = m_q.size();
    for (int i = 0; i < n; i++) step(1'b0, 16'h0, 1'b1, 1'b0);
    step(push_at_end, 16'h5555, 1'b1, clr);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    repeat (2) @(negedge clk);
    check("rst_sample_out", 32'(sample_out), 32'h0);
    check("rst_underrun_count", 32'(underrun_count), 32'h0);
    check("rst_primed", 32'(primed), 32'h0);
    check("rst_level", 32'(level), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h1);
    reset = 1'b1;

    // Below half-full: accepts give fill value, no priming.
    step(1'b1, 16'h00A1, 1'b0, 1'b0);
    step(1'b1, 16'h00A2, 1'b0, 1'b0);
    step(1'b1, 16'h00A3, 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b1, 1'b0);
    step(1'b0, 16'h0, 1'b1, 1'b0);
    check("t1_sample_out", 32'(sample_out), 32'h0);
    check("t1_primed", 32'(primed), 32'h0);
    check("t1_underruns", 32'(underrun_count), 32'h0);
    check("t1_level", 32'(level), 32'h3);

    // Prime with 1..4 and play them back in order.
    do_reset();
    for (int i = 1; i <= 4; i++) step(1'b1, 16'(i), 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      step(1'b0, 16'h0, 1'b1, 1'b0);
      check("t2_primed", 32'(primed), 32'h1);
      check("t2_sample_out", 32'(sample_out), 32'(i));
    end
    check("t2_level", 32'(level), 32'h0);

    // Accept on empty while running: underrun.
    step(1'b0, 16'h0, 1'b1, 1'b0);
    check("t3_underruns", 32'(underrun_count), 32'h1);
    check("t3_primed", 32'(primed), 32'h0);
    check("t3_sample_out", 32'(sample_out), 32'(UNDERRUN_FILL));

    // Fill to full, then push+accept at full: pop only.
    for (int i = 0; i < 8; i++) begin
      check("t4_ready_before_push", 32'(in_ready), 32'h1);
      step(1'b1, 16'h0010 + 16'(i), 1'b0, 1'b0);
    end
    check("t4_in_ready_full", 32'(in_ready), 32'h0);
    check("t4_level_full", 32'(level), 32'h8);
    step(1'b1, 16'h0099, 1'b1, 1'b0);
    check("t4_level_after", 32'(level), 32'h7);
    check("t4_sample_out", 32'(sample_out), 32'h0010);
    for (int i = 1; i < 8; i++) begin
      step(1'b0, 16'h0, 1'b1, 1'b0);
      check("t4_drain", 32'(sample_out), 32'h0010 + 32'(i));
    end
    step(1'b0, 16'h0, 1'b1, 1'b0);
    check("t4_underruns", 32'(underrun_count), 32'h2);

    // Underruns, including push on the underrun cycle, then saturation and clear.
    run_underrun(1'b0, 1'b0);
    check("t5_underruns_3", 32'(underrun_count), 32'h3);
    run_underrun(1'b1, 1'b0);
    check("t5_underruns_4", 32'(underrun_count), 32'h4);
    check("t5_push_on_underrun_level", 32'(level), 32'h1);
    check("t5_push_on_underrun_primed", 32'(primed), 32'h0);
    force dut.underrun_count_reg = 16'hFFFE;
    m_cnt = 16'hFFFE;
    step(1'b0, 16'h0, 1'b0, 1'b0);
    release dut.underrun_count_reg;
    run_underrun(1'b0, 1'b0);
    check("t5_count_ffff", 32'(underrun_count), 32'hFFFF);
    run_underrun(1'b0, 1'b0);
    check("t5_count_saturated", 32'(underrun_count), 32'hFFFF);
    run_underrun(1'b0, 1'b1);
    check("t5_clear_wins", 32'(underrun_count), 32'h0);

    // Mid-stream asynchronous reset, then re-prime.
    do_reset();
    step(1'b1, 16'h1234, 1'b0, 1'b0);
    for (int i = 1; i <= 5; i++) step(1'b1, 16'h2000 + 16'(i), 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b1, 1'b0);
    check("t6_pre_level", 32'(level), 32'h5);
    check("t6_pre_sample_out", 32'(sample_out), 32'h1234);
    reset = 1'b0;
    #1;
    check("t6_async_sample_out", 32'(sample_out), 32'h0);
    check("t6_async_level", 32'(level), 32'h0);
    check("t6_async_primed", 32'(primed), 32'h0);
    check("t6_async_in_ready", 32'(in_ready), 32'h1);
    check("t6_async_underruns", 32'(underrun_count), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 1; i <= 4; i++) step(1'b1, 16'h3000 + 16'(i), 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b0, 1'b0);
    check("t6_reprimed", 32'(primed), 32'h1);
    check("t6_reprime_level", 32'(level), 32'h4);
    step(1'b0, 16'h0, 1'b1, 1'b0);
    check("t6_first_pop", 32'(sample_out), 32'h3001);
    check("t6_level_after_pop", 32'(level), 32'h3);

    step(1'b0, 16'h0, 1'b0, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sample_buffer.md
# sample_buffer

Elastic PCM sample FIFO between the music player's sample generator and the AC97 codec interface. The generator pushes samples with a valid/ready handshake. The codec's per-frame accept pulse pops one sample onto a registered output. The buffer primes to half-full before playback and tracks underruns with a saturating counter. It absorbs generator jitter, such as a note change or harmonics recompute, so that the codec always sees a defined sample every frame.

## Interface
- WIDTH, 16, sample width in bits (two's complement PCM)
- DEPTH, 8, FIFO entries; power of two, at least 4
- AW, $clog2(DEPTH), pointer width (derived; not overridden)

- clk  in  1  system clock; the codec interface also runs on it
- reset  in  1  reset, asynchronous, active-low
- in_sample  in  WIDTH  sample from the generator
- in_valid  in  1  in_sample is valid this cycle
- in_ready  out  1  buffer can take a sample this cycle
- accept  in  1  codec frame-accept pulse, 1 cycle wide
- sample_out  out  WIDTH  registered sample presented to the codec
- level  out  AW+1  current occupancy, 0..DEPTH
- primed  out  1  FSM is in RUN
- underrun_count  out  16  number of underruns; saturates at 16'hFFFF
- clear_stats  in  1  synchronous clear of underrun_count

## Operation
- Storage is a DEPTH-entry array with rd_ptr and wr_ptr, each AW+1 bits. The extra MSB disambiguates full from empty.
  - level = wr_ptr - rd_ptr, computed modulo 2^(AW+1).
  - full when level == DEPTH; empty when level == 0.
- Push occurs when in_valid && in_ready. in_ready = ~full.
- FSM has two states, FILL and RUN. The reset state is FILL.
- In FILL:
  - Pushes are accepted; no pops occur.
  - An accept pulse drives sample_out with the fill value (see Configuration). The underrun counter does not change.
  - The FSM moves to RUN on the cycle after level >= DEPTH/2.
- In RUN:
  - On accept with the buffer not empty, sample_out <= mem[rd_ptr] and rd_ptr increments.
  - On accept with the buffer empty, this is an underrun:
    - sample_out <= fill value
    - underrun_count increments (saturating)
    - FSM goes to FILL
- Simultaneous push and pop in RUN are both performed; level is unchanged.
- Empty with a push and an accept in the same cycle: no bypass. This is an underrun, and the pushed sample is stored.
- Full with an accept in the same cycle: the pop happens. in_ready was already 0 that cycle, so no push occurs.
- Pointers wrap naturally at 2^(AW+1).
- clear_stats zeroes underrun_count. If it coincides with an underrun, the clear wins.
- Asserting reset at any point returns the block to the reset state immediately:
  - pointers = 0, FSM = FILL
  - sample_out = 0, underrun_count = 0
  - Buffered samples are discarded; the array contents need not be cleared.

## Timing
- Reset values:
  - sample_out = 0, underrun_count = 0, primed = 0
  - level = 0, in_ready = 1
- Push to level: level increments on the clock edge after the handshake cycle.
- Accept to sample_out: sample_out updates on the edge ending the accept cycle and holds until the next accept.
- in_ready, level and primed are derived from registers only. There are no combinational paths from input to output.
- Priming: the first sample is popped at the first accept at least 2 cycles after the push that brings level to DEPTH/2. One cycle is for the level update and one is for the FILL to RUN transition.
- accept asserted for more than 1 cycle is treated as one pop per cycle. Upstream must not do this.

## Configuration
- Macro: SAMPLE_BUFFER_HOLD_EN.
- Defined: the fill value is the current sample_out. The last sample is repeated during FILL and on underrun, which avoids clicks. After reset it is 0.
- Undefined: the fill value is always 0 (silence).
- In both cases, sample_out is 0 after reset until the first real pop.

## Test plan
- Reset, then push 3 samples (DEPTH=8) and pulse accept twice: sample_out stays 0, primed = 0, underrun_count = 0, level = 3.
- Push 16'h0001..16'h0004, wait 2 cycles, then pulse accept 4 times: primed = 1, sample_out = 1, 2, 3, 4 in order, level returns to 0.
- From RUN with the buffer empty, pulse accept:
  - underrun_count = 1, primed = 0
  - sample_out = 16'h0004 with the macro, 16'h0000 without it
- Push continuously with in_valid = 1 and no accepts: in_ready falls after 8 pushes and level = 8. A push-and-accept cycle at full gives no write and level = 7 afterwards.
- Force 65537 underruns: underrun_count = 16'hFFFF. Assert clear_stats on the same cycle as an underrun: the count becomes 0.
- Assert reset mid-stream with level = 5 and sample_out = 16'h1234: all outputs return to their reset values immediately, and the next 4 pushes re-prime the buffer.
